multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control unit (FETCH/DCD/EXE/MEM/WB)
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_in,
  input  logic [5:0] funct_in,
  input  logic       zero_in,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] Extop,
  output logic [2:0] ALUctr,
  output logic [1:0] NPCop,
  output logic [2:0] state_out,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [2:0] S_FETCH = 3'b000;
  localparam logic [2:0] S_DCD   = 3'b001;
  localparam logic [2:0] S_EXE   = 3'b010;
  localparam logic [2:0] S_MEM   = 3'b011;
  localparam logic [2:0] S_WB    = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  logic [2:0] state_q, state_d;
  // Set for the one cycle after a reset edge so that cycle is fully quiet.
  logic       rst_q;

  logic is_rtype, is_addu, is_subu, is_slt, is_jr;
  logic is_j, is_jal, is_beq, is_addi, is_addiu, is_ori, is_lui, is_lw, is_sw;
  logic is_alu, is_legal;

  assign is_rtype = (opcode_in == OP_RTYPE);
  assign is_addu  = is_rtype && (funct_in == FN_ADDU);
  assign is_subu  = is_rtype && (funct_in == FN_SUBU);
  assign is_slt   = is_rtype && (funct_in == FN_SLT);
  assign is_jr    = is_rtype && (funct_in == FN_JR);
  assign is_j     = (opcode_in == OP_J);
  assign is_jal   = (opcode_in == OP_JAL);
  assign is_beq   = (opcode_in == OP_BEQ);
  assign is_addi  = (opcode_in == OP_ADDI);
  assign is_addiu = (opcode_in == OP_ADDIU);
  assign is_ori   = (opcode_in == OP_ORI);
  assign is_lui   = (opcode_in == OP_LUI);
  assign is_lw    = (opcode_in == OP_LW);
  assign is_sw    = (opcode_in == OP_SW);

  assign is_alu   = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi | is_addiu;
  assign is_legal = is_alu | is_lw | is_sw | is_beq | is_j | is_jal | is_jr;

  assign state_out = state_q;

  // State register; reset parks the FSM in FETCH and arms the quiet cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
    end
  end

  // Datapath steering decoded purely from the instruction, independent of state.
  always_comb begin
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrc   = 1'b0;
    Extop    = 2'b00;
    ALUctr   = 3'b001;
    if (is_rtype) RegDst = 2'b01;
    if (is_jal) begin
      RegDst   = 2'b10;
      MemtoReg = 2'b10;
    end
    if (is_lw) MemtoReg = 2'b01;
    if (is_ori | is_lui | is_lw | is_sw | is_addi | is_addiu) ALUSrc = 1'b1;
    if (is_lui) Extop = 2'b01;
    if (is_lw | is_sw | is_addi | is_addiu | is_beq) Extop = 2'b10;
    if (is_subu | is_beq) ALUctr = 3'b010;
    if (is_slt) ALUctr = 3'b011;
    if (is_ori) ALUctr = 3'b100;
  end

  // Next-state and strobe generation; strobes are silenced in the post-reset cycle.
  always_comb begin
    state_d    = state_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    NPCop      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DCD;
        end
      end
      S_DCD: begin
        state_d = S_FETCH;
        if (is_j) begin
          PCWr       = 1'b1;
          NPCop      = 2'b10;
          instr_done = 1'b1;
        end else if (is_jal) begin
          PCWr       = 1'b1;
          NPCop      = 2'b10;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end else if (is_jr) begin
          PCWr       = 1'b1;
          NPCop      = 2'b11;
          instr_done = 1'b1;
        end else if (!is_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq) begin
          PCWr       = zero_in;
          NPCop      = 2'b01;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst_q) begin
      state_d    = S_FETCH;
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      NPCop      = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_in, funct_in;
  logic       zero_in, mem_ready;
  logic       PCWr, IRWr, RegWrite, MemRead, MemWrite, ALUSrc, instr_done, illegal;
  logic [1:0] RegDst, MemtoReg, Extop, NPCop;
  logic [2:0] ALUctr, state_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .funct_in(funct_in),
    .zero_in(zero_in), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Extop(Extop), .ALUctr(ALUctr),
    .NPCop(NPCop), .state_out(state_out), .instr_done(instr_done), .illegal(illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Runs one instruction from a FETCH cycle with mem_ready=1 and checks its latency.
  task automatic run_lat(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int exp_lat);
    int n;
    logic viol;
    opcode_in = op;
    funct_in  = fn;
    zero_in   = z;
    mem_ready = 1'b1;
    #1;
    n    = 1;
    viol = 1'b0;
    while (!instr_done && n < 20) begin
      step();
      n++;
    end
    for (int k = 0; k < 1; k++) begin
      if (MemWrite && (RegWrite || PCWr)) viol = 1'b1;
      if (RegWrite && PCWr && op != 6'b000011) viol = 1'b1;
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_excl"}, viol, 1'b0);
    step();
    check_eq({tag, "_back_fetch"}, state_out, 3'b000);
  endtask

  initial begin
    int t0;
    reset = 1'b1; opcode_in = 6'd0; funct_in = 6'd0; zero_in = 1'b0; mem_ready = 1'b0;
    step();
    check_eq("rst_state", state_out, 3'b000);
    check_eq("rst_memread", MemRead, 1'b0);
    check_eq("rst_done", instr_done, 1'b0);
    reset = 1'b0;
    step();
    check_eq("post_rst_state", state_out, 3'b000);
    check_eq("post_rst_memread", MemRead, 1'b1);

    // addu: FETCH, DCD, EXE, WB
    opcode_in = 6'b000000; funct_in = 6'b100001; mem_ready = 1'b1; t0 = cyc;
    #1;
    check_eq("addu_f_irwr", IRWr, 1'b1);
    check_eq("addu_f_pcwr", PCWr, 1'b1);
    step();
    check_eq("addu_d_state", state_out, 3'b001);
    check_eq("addu_d_regwr", RegWrite, 1'b0);
    step();
    check_eq("addu_e_state", state_out, 3'b010);
    check_eq("addu_e_regwr", RegWrite, 1'b0);
    step();
    check_eq("addu_wb_state", state_out, 3'b100);
    check_eq("addu_wb_regwr", RegWrite, 1'b1);
    check_eq("addu_wb_regdst", RegDst, 2'b01);
    check_eq("addu_wb_aluctr", ALUctr, 3'b001);
    check_eq("addu_wb_done", instr_done, 1'b1);
    check_eq("addu_cycles", cyc - t0 + 1, 4);
    step();

    // lw with three wait cycles in MEM
    opcode_in = 6'b100011; funct_in = 6'd0; mem_ready = 1'b1; t0 = cyc;
    step();
    step();
    check_eq("lw_e_alusrc", ALUSrc, 1'b1);
    check_eq("lw_e_extop", Extop, 2'b10);
    check_eq("lw_e_aluctr", ALUctr, 3'b001);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("lw_mem_state", state_out, 3'b011);
      check_eq("lw_mem_read", MemRead, 1'b1);
      check_eq("lw_mem_done", instr_done, 1'b0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("lw_mem_last_state", state_out, 3'b011);
    step();
    check_eq("lw_wb_state", state_out, 3'b100);
    check_eq("lw_wb_regwr", RegWrite, 1'b1);
    check_eq("lw_wb_memtoreg", MemtoReg, 2'b01);
    check_eq("lw_wb_regdst", RegDst, 2'b00);
    check_eq("lw_wb_extop", Extop, 2'b10);
    check_eq("lw_wb_done", instr_done, 1'b1);
    check_eq("lw_cycles", cyc - t0 + 1, 8);
    step();

    // beq taken then not taken
    opcode_in = 6'b000100; zero_in = 1'b1;
    step();
    step();
    check_eq("beq1_state", state_out, 3'b010);
    check_eq("beq1_pcwr", PCWr, 1'b1);
    check_eq("beq1_npcop", NPCop, 2'b01);
    check_eq("beq1_aluctr", ALUctr, 3'b010);
    check_eq("beq1_done", instr_done, 1'b1);
    step();
    zero_in = 1'b0;
    step();
    step();
    check_eq("beq0_pcwr", PCWr, 1'b0);
    check_eq("beq0_done", instr_done, 1'b1);
    step();

    // jal completes in DCD
    opcode_in = 6'b000011;
    step();
    check_eq("jal_pcwr", PCWr, 1'b1);
    check_eq("jal_regwr", RegWrite, 1'b1);
    check_eq("jal_regdst", RegDst, 2'b10);
    check_eq("jal_memtoreg", MemtoReg, 2'b10);
    check_eq("jal_npcop", NPCop, 2'b10);
    step();
    check_eq("jal_next", state_out, 3'b000);

    // jr selects the register target
    opcode_in = 6'b000000; funct_in = 6'b001000;
    step();
    check_eq("jr_npcop", NPCop, 2'b11);
    check_eq("jr_pcwr", PCWr, 1'b1);
    step();

    // undecoded opcode
    opcode_in = 6'b111111; funct_in = 6'd0;
    step();
    check_eq("ill_pulse", illegal, 1'b1);
    check_eq("ill_done", instr_done, 1'b1);
    check_eq("ill_strobes", {PCWr, RegWrite, MemWrite, MemRead, IRWr}, 5'b00000);
    step();
    check_eq("ill_next", state_out, 3'b000);
    check_eq("ill_clear", illegal, 1'b0);

    // zero-wait latencies
    run_lat("j",     6'b000010, 6'd0,      1'b0, 2);
    run_lat("jal",   6'b000011, 6'd0,      1'b0, 2);
    run_lat("jr",    6'b000000, 6'b001000, 1'b0, 2);
    run_lat("beq",   6'b000100, 6'd0,      1'b1, 3);
    run_lat("sw",    6'b101011, 6'd0,      1'b0, 4);
    run_lat("subu",  6'b000000, 6'b100011, 1'b0, 4);
    run_lat("slt",   6'b000000, 6'b101010, 1'b0, 4);
    run_lat("ori",   6'b001101, 6'd0,      1'b0, 4);
    run_lat("lui",   6'b001111, 6'd0,      1'b0, 4);
    run_lat("addi",  6'b001000, 6'd0,      1'b0, 4);
    run_lat("addiu", 6'b001001, 6'd0,      1'b0, 4);
    run_lat("lw",    6'b100011, 6'd0,      1'b0, 5);
    run_lat("badfn", 6'b000000, 6'b000000, 1'b0, 2);

    // reset during sw MEM wait
    opcode_in = 6'b101011; funct_in = 6'd0; mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    check_eq("sw_mem_write", MemWrite, 1'b1);
    step();
    check_eq("sw_wait_write", MemWrite, 1'b1);
    reset = 1'b1;
    step();
    check_eq("swrst_memwrite", MemWrite, 1'b0);
    check_eq("swrst_state", state_out, 3'b000);
    check_eq("swrst_done", instr_done, 1'b0);
    check_eq("swrst_memread", MemRead, 1'b0);
    reset = 1'b0;
    step();
    check_eq("swrst_fetch", MemRead, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
